// File: rtl/wb_arb_pkg.sv
// Shared defaults and types for the register-file writeback arbiter.
// Imported by wb_fifo and wb_arbiter.
package wb_arb_pkg;

   localparam int DEF_DATA_W  = 16;
   localparam int DEF_RADDR_W = 4;
   localparam int REG_ZERO    = 0;
   localparam int STARVE_W    = 4;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_PIPE,
      SRC_FIFO
   } wr_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding multi-cycle results until they win the write port.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module wb_fifo
   import wb_arb_pkg::*;
#(
   parameter int WIDTH = 20,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]      fill;
   logic [WIDTH-1:0] mem_q [DEPTH];

   always_comb begin
      fill      = wr_ptr_q - rd_ptr_q;
      empty     = (fill == '0);
      full      = (fill == (AW+1)'(DEPTH));
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      head_data = mem_q[rd_ptr_q[AW-1:0]];
      // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
      if (push && !full) begin
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (pop && !empty) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// Shares the register-file write port between pipeline writeback and buffered
// multi-cycle results; the pipeline wins unless the FIFO head has waited too long.
module wb_arbiter
   import wb_arb_pkg::*;
#(
   parameter int DATA_W       = DEF_DATA_W,
   parameter int RADDR_W      = DEF_RADDR_W,
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pipe_wr_en,
   input  logic [RADDR_W-1:0] pipe_rd,
   input  logic [DATA_W-1:0]  pipe_data,
   input  logic               mc_valid,
   output logic               mc_ready,
   input  logic [RADDR_W-1:0] mc_rd,
   input  logic [DATA_W-1:0]  mc_data,
   output logic               rf_we,
   output logic [RADDR_W-1:0] rf_waddr,
   output logic [DATA_W-1:0]  rf_wdata,
   output logic               pipe_stall,
   output logic               mc_pending
);

   localparam int ENTRY_W = RADDR_W + DATA_W;

   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
   logic                pipe_req;
   logic                starve_hit;
   logic                fifo_grant;
   logic                fifo_full;
   logic                fifo_empty;
   logic                mc_push;
   logic [ENTRY_W-1:0]  head_entry;
   logic [RADDR_W-1:0]  head_rd;
   logic [DATA_W-1:0]   head_data;
   wr_src_e             wr_src;

   assign head_rd   = head_entry[ENTRY_W-1:DATA_W];
   assign head_data = head_entry[DATA_W-1:0];

   wb_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (mc_push),
      .push_data ({mc_rd, mc_data}),
      .pop       (fifo_grant),
      .head_data (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Gating with reset keeps every output quiet while reset is held, not just the state.
   always_comb begin
      pipe_req   = !reset && pipe_wr_en && (pipe_rd != RADDR_W'(REG_ZERO));
      starve_hit = (starve_cnt_q == STARVE_W'(STARVE_LIMIT));
      fifo_grant = !reset && !fifo_empty && (!pipe_req || starve_hit);
      pipe_stall = pipe_req && fifo_grant;
      mc_ready   = !reset && !fifo_full;
      mc_pending = !reset && !fifo_empty;
      mc_push    = mc_valid && mc_ready;
   end

   always_comb begin
      wr_src   = SRC_NONE;
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      if (fifo_grant) begin
         wr_src = SRC_FIFO;
      end else if (pipe_req) begin
         wr_src = SRC_PIPE;
      end
      // A head entry targeting r0 still pops, it just never writes.
      case (wr_src)
         SRC_FIFO: begin
            rf_we    = (head_rd != RADDR_W'(REG_ZERO));
            rf_waddr = head_rd;
            rf_wdata = head_data;
         end
         SRC_PIPE: begin
            rf_we    = 1'b1;
            rf_waddr = pipe_rd;
            rf_wdata = pipe_data;
         end
         default: begin
            rf_we    = 1'b0;
         end
      endcase
   end

   // Counts cycles the head loses to the pipeline; a grant or empty FIFO resets the wait.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (fifo_empty || fifo_grant) begin
         starve_cnt_d = '0;
      end else if (pipe_req && !starve_hit) begin
         starve_cnt_d = starve_cnt_q + STARVE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter, checked against a queue-based
// model of the arbitration rules.
module tb_wb_arbiter;

   localparam int DATA_W       = 16;
   localparam int RADDR_W      = 4;
   localparam int FIFO_DEPTH   = 2;
   localparam int STARVE_LIMIT = 4;

   logic               clk;
   logic               reset;
   logic               pipe_wr_en;
   logic [RADDR_W-1:0] pipe_rd;
   logic [DATA_W-1:0]  pipe_data;
   logic               mc_valid;
   logic               mc_ready;
   logic [RADDR_W-1:0] mc_rd;
   logic [DATA_W-1:0]  mc_data;
   logic               rf_we;
   logic [RADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0]  rf_wdata;
   logic               pipe_stall;
   logic               mc_pending;

   typedef struct packed {
      logic [RADDR_W-1:0] rd;
      logic [DATA_W-1:0]  data;
   } entry_t;

   entry_t model_q[$];
   int     model_starve;
   int     checks;
   int     errors;

   logic               obs_we;
   logic               obs_stall;
   logic               obs_ready;
   logic [RADDR_W-1:0] obs_waddr;
   logic [DATA_W-1:0]  obs_wdata;

   wb_arbiter #(
      .DATA_W       (DATA_W),
      .RADDR_W      (RADDR_W),
      .FIFO_DEPTH   (FIFO_DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pipe_wr_en (pipe_wr_en),
      .pipe_rd    (pipe_rd),
      .pipe_data  (pipe_data),
      .mc_valid   (mc_valid),
      .mc_ready   (mc_ready),
      .mc_rd      (mc_rd),
      .mc_data    (mc_data),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .pipe_stall (pipe_stall),
      .mc_pending (mc_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One cycle: drive at negedge, compare against the model, advance the model at posedge.
   task automatic applyStimulus(input logic we, input logic [RADDR_W-1:0] rd, input logic [DATA_W-1:0] data,
                                input logic v, input logic [RADDR_W-1:0] mrd, input logic [DATA_W-1:0] mdata);
      bit                 preq;
      bit                 nonempty;
      bit                 is_full;
      bit                 grant;
      bit                 accept;
      logic               exp_we;
      logic [RADDR_W-1:0] exp_addr;
      logic [DATA_W-1:0]  exp_data;
      @(negedge clk);
      pipe_wr_en = we;
      pipe_rd    = rd;
      pipe_data  = data;
      mc_valid   = v;
      mc_rd      = mrd;
      mc_data    = mdata;
      #1;
      preq     = we && (rd != 0);
      nonempty = (model_q.size() != 0);
      is_full  = (model_q.size() == FIFO_DEPTH);
      grant    = nonempty && (!preq || model_starve == STARVE_LIMIT);
      accept   = v && !is_full;
      exp_we   = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      if (grant) begin
         exp_we   = (model_q[0].rd != 0);
         exp_addr = model_q[0].rd;
         exp_data = model_q[0].data;
      end else if (preq) begin
         exp_we   = 1'b1;
         exp_addr = rd;
         exp_data = data;
      end
      checkOutput("rf_we", 32'(rf_we), 32'(exp_we));
      checkOutput("rf_waddr", 32'(rf_waddr), 32'(exp_addr));
      checkOutput("rf_wdata", 32'(rf_wdata), 32'(exp_data));
      checkOutput("pipe_stall", 32'(pipe_stall), 32'(preq && grant));
      checkOutput("mc_ready", 32'(mc_ready), 32'(!is_full));
      checkOutput("mc_pending", 32'(mc_pending), 32'(nonempty));
      obs_we    = rf_we;
      obs_stall = pipe_stall;
      obs_ready = mc_ready;
      obs_waddr = rf_waddr;
      obs_wdata = rf_wdata;
      @(posedge clk);
      if (grant) begin
         void'(model_q.pop_front());
      end
      if (accept) begin
         model_q.push_back('{rd: mrd, data: mdata});
      end
      if (!nonempty || grant) begin
         model_starve = 0;
      end else if (preq && model_starve < STARVE_LIMIT) begin
         model_starve++;
      end
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   // Reset with busy inputs applied: every output must read zero while it is held.
   task automatic doReset();
      @(negedge clk);
      reset      = 1'b1;
      pipe_wr_en = 1'b1;
      pipe_rd    = 4'd9;
      pipe_data  = 16'hDEAD;
      mc_valid   = 1'b1;
      mc_rd      = 4'd2;
      mc_data    = 16'hBEEF;
      #1;
      checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
      checkOutput("rst_rf_waddr", 32'(rf_waddr), 32'd0);
      checkOutput("rst_rf_wdata", 32'(rf_wdata), 32'd0);
      checkOutput("rst_pipe_stall", 32'(pipe_stall), 32'd0);
      checkOutput("rst_mc_ready", 32'(mc_ready), 32'd0);
      checkOutput("rst_mc_pending", 32'(mc_pending), 32'd0);
      model_q.delete();
      model_starve = 0;
      @(negedge clk);
      reset      = 1'b0;
      pipe_wr_en = 1'b0;
      mc_valid   = 1'b0;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      model_starve = 0;
      reset        = 1'b1;
      pipe_wr_en   = 1'b0;
      pipe_rd      = '0;
      pipe_data    = '0;
      mc_valid     = 1'b0;
      mc_rd        = '0;
      mc_data      = '0;
      doReset();

      // Idle pipeline: a pushed result is written in the following cycle.
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd5, 16'h1234);
      idleCycle();
      checkOutput("s1_we", 32'(obs_we), 32'd1);
      checkOutput("s1_waddr", 32'(obs_waddr), 32'd5);
      checkOutput("s1_wdata", 32'(obs_wdata), 32'h1234);
      idleCycle();

      // Continuous pipe writes: four pipe wins, then one forced FIFO grant with stall.
      applyStimulus(1'b1, 4'd3, 16'hAAAA, 1'b1, 4'd7, 16'h5555);
      for (int i = 0; i < STARVE_LIMIT; i++) begin
         applyStimulus(1'b1, 4'd3, 16'hAAAA, 1'b0, '0, '0);
         checkOutput("s2_pipe_waddr", 32'(obs_waddr), 32'd3);
         checkOutput("s2_pipe_stall", 32'(obs_stall), 32'd0);
      end
      applyStimulus(1'b1, 4'd3, 16'hAAAA, 1'b0, '0, '0);
      checkOutput("s2_force_stall", 32'(obs_stall), 32'd1);
      checkOutput("s2_force_waddr", 32'(obs_waddr), 32'd7);
      checkOutput("s2_force_wdata", 32'(obs_wdata), 32'h5555);
      applyStimulus(1'b1, 4'd3, 16'hAAAA, 1'b0, '0, '0);
      checkOutput("s2_after_waddr", 32'(obs_waddr), 32'd3);
      checkOutput("s2_after_stall", 32'(obs_stall), 32'd0);
      idleCycle();

      // Fill the FIFO under pipe pressure; the third result is refused.
      applyStimulus(1'b1, 4'd3, 16'hAAAA, 1'b1, 4'd1, 16'h1111);
      applyStimulus(1'b1, 4'd3, 16'hAAAA, 1'b1, 4'd2, 16'h2222);
      applyStimulus(1'b1, 4'd3, 16'hAAAA, 1'b1, 4'd4, 16'h4444);
      checkOutput("s3_ready_full", 32'(obs_ready), 32'd0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b1, 4'd3, 16'hAAAA, 1'b0, '0, '0);
      end
      repeat (3) idleCycle();

      // Pipe write to r0 is not a request; FIFO entry to r0 pops silently.
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd6, 16'h6666);
      applyStimulus(1'b1, 4'd0, 16'hBEEF, 1'b0, '0, '0);
      checkOutput("s4_we", 32'(obs_we), 32'd1);
      checkOutput("s4_waddr", 32'(obs_waddr), 32'd6);
      checkOutput("s4_stall", 32'(obs_stall), 32'd0);
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'h0F0F);
      idleCycle();
      checkOutput("s4_r0_we", 32'(obs_we), 32'd0);
      idleCycle();

      // Push while popping with one entry held keeps arrival order.
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd8, 16'h0801);
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd9, 16'h0902);
      checkOutput("s5_first", 32'(obs_waddr), 32'd8);
      applyStimulus(1'b0, 4'd0, 16'h0, 1'b1, 4'd10, 16'h0A03);
      checkOutput("s5_second", 32'(obs_waddr), 32'd9);
      idleCycle();
      checkOutput("s5_third", 32'(obs_waddr), 32'd10);
      idleCycle();

      // Reset with two entries buffered and the wait counter at three.
      applyStimulus(1'b1, 4'd3, 16'hAAAA, 1'b1, 4'd1, 16'h1111);
      applyStimulus(1'b1, 4'd3, 16'hAAAA, 1'b1, 4'd2, 16'h2222);
      applyStimulus(1'b1, 4'd3, 16'hAAAA, 1'b0, '0, '0);
      applyStimulus(1'b1, 4'd3, 16'hAAAA, 1'b0, '0, '0);
      doReset();
      applyStimulus(1'b1, 4'd4, 16'h4444, 1'b0, '0, '0);
      checkOutput("s6_ready", 32'(obs_ready), 32'd1);
      checkOutput("s6_stall", 32'(obs_stall), 32'd0);
      checkOutput("s6_waddr", 32'(obs_waddr), 32'd4);

      // Random traffic with occasional resets.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            doReset();
         end else begin
            applyStimulus($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), 16'($urandom),
                          $urandom_range(0, 9) < 4, 4'($urandom_range(0, 15)), 16'($urandom));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
